// File: rtl/instruction_prefetch_if.sv
// Bundle of the instruction fetch front-end's handshake and bus signals.
//   master : the prefetch unit (drives ibus requests and the ins port)
//   slave  : its environment (memory agent plus CPU core)
// Signals:
//   redirect, redirect_pc            core -> prefetch, flush and restart fetch
//   ins_valid, ins, ins_pc, ins_ready  FIFO head handed to the core (valid/ready)
//   ibus_address, ibus_read, ibus_byteenable  Avalon-MM read request
//   ibus_waitrequest, ibus_readdatavalid, ibus_readdata  Avalon-MM agent side
interface instruction_prefetch_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ins_valid;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        ins_ready;
   logic [31:0] ibus_address;
   logic        ibus_read;
   logic [3:0]  ibus_byteenable;
   logic        ibus_waitrequest;
   logic        ibus_readdatavalid;
   logic [31:0] ibus_readdata;

   modport master (
      input  redirect, redirect_pc, ins_ready,
      input  ibus_waitrequest, ibus_readdatavalid, ibus_readdata,
      output ins_valid, ins, ins_pc,
      output ibus_address, ibus_read, ibus_byteenable
   );

   modport slave (
      output redirect, redirect_pc, ins_ready,
      output ibus_waitrequest, ibus_readdatavalid, ibus_readdata,
      input  ins_valid, ins, ins_pc,
      input  ibus_address, ibus_read, ibus_byteenable
   );
endinterface

// File: rtl/instruction_prefetch.sv
// Instruction prefetch front-end. Issues pipelined sequential 32-bit Avalon-MM reads ahead
// of execution, buffers returned words with their fetch addresses in a DEPTH-entry FIFO and
// presents the head to the core over valid/ready. A redirect empties the FIFO, marks every
// outstanding read as stale and restarts fetching at the new word-aligned PC.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - instruction_prefetch_if.master: redirect, ins handshake and ibus read port
// Parameters:
//   DEPTH    - FIFO entries and cap on buffered + in-flight reads (power of two, 2..16)
//   RESET_PC - first fetch address after reset
module instruction_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic                    clk,
   input logic                    rst,
   instruction_prefetch_if.master bus
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   typedef enum logic [0:0] {StRun, StHold} state_e;

   state_e          state_q, state_d;
   logic            read_q, read_d;
   logic [31:0]     addr_q, addr_d;
   logic            stale_q, stale_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     resp_pc_q, resp_pc_d;
   logic [CntW-1:0] inflight_q, inflight_d;
   logic [CntW-1:0] discard_q, discard_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

   logic [31:0]     mem_data [DEPTH];
   logic [31:0]     mem_pc   [DEPTH];

   logic            accept, hold, rvalid, push, pop, issue, head_valid;
   logic [CntW:0]   credit;
   logic [31:0]     redir_pc;
   logic            unused_pc_lsb;

   assign unused_pc_lsb = ^bus.redirect_pc[1:0];
   assign head_valid    = (count_q != '0);

   always_comb begin
      redir_pc = {bus.redirect_pc[31:2], 2'b00};
      accept   = read_q & ~bus.ibus_waitrequest;
      hold     = read_q & bus.ibus_waitrequest;
      // A response with nothing outstanding is a protocol error and is ignored.
      rvalid   = bus.ibus_readdatavalid & (inflight_q != '0);
      push     = rvalid & (discard_q == '0) & ~bus.redirect;
      pop      = head_valid & bus.ins_ready & ~bus.redirect;

      inflight_d = inflight_q;
      if (accept) inflight_d = inflight_d + CntW'(1);
      if (rvalid) inflight_d = inflight_d - CntW'(1);

      // A read held across a redirect belongs to the old stream; it joins the discard
      // count at the moment it is accepted.
      discard_d = discard_q;
      if (rvalid && (discard_q != '0)) discard_d = discard_d - CntW'(1);
      if (accept && stale_q)           discard_d = discard_d + CntW'(1);
      if (bus.redirect)                discard_d = inflight_d;

      stale_d = stale_q;
      if (accept)              stale_d = 1'b0;
      if (bus.redirect && hold) stale_d = 1'b1;

      // fetch_pc already points into the new stream when a stale read is accepted.
      fetch_pc_d = fetch_pc_q;
      if (accept && !stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
      if (bus.redirect)       fetch_pc_d = redir_pc;

      resp_pc_d = resp_pc_q;
      if (push)         resp_pc_d = resp_pc_q + 32'd4;
      if (bus.redirect) resp_pc_d = redir_pc;

      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      if (bus.redirect) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end

      // Credit uses post-cycle occupancy so an accept next cycle can never overflow the FIFO.
      credit = {1'b0, count_d} + {1'b0, inflight_d};
      issue  = ~bus.redirect & (credit < (CntW + 1)'(DEPTH));

      state_d = state_q;
      read_d  = issue;
      addr_d  = issue ? fetch_pc_d : '0;
      unique case (state_q)
         StRun: begin
            if (hold) begin
               state_d = StHold;
               read_d  = 1'b1;
               addr_d  = addr_q;
            end
         end
         StHold: begin
            if (bus.ibus_waitrequest) begin
               read_d = 1'b1;
               addr_d = addr_q;
            end else begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StRun;
         read_q     <= 1'b0;
         addr_q     <= '0;
         stale_q    <= 1'b0;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         read_q     <= read_d;
         addr_q     <= addr_d;
         stale_q    <= stale_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr_q] <= bus.ibus_readdata;
         mem_pc[wr_ptr_q]   <= resp_pc_q;
      end
   end

   assign bus.ibus_read       = read_q;
   assign bus.ibus_address    = addr_q;
   assign bus.ibus_byteenable = 4'b1111;
   assign bus.ins_valid       = head_valid;
   assign bus.ins             = head_valid ? mem_data[rd_ptr_q] : '0;
   assign bus.ins_pc          = head_valid ? mem_pc[rd_ptr_q] : '0;

   a_no_orphan_response : assert property (
      @(posedge clk) disable iff (!rst) bus.ibus_readdatavalid |-> (inflight_q != '0)
   );

endmodule

// File: tb/tb_instruction_prefetch.sv
module tb_instruction_prefetch;

   logic clk;
   logic rst;
   int   checks;
   int   passed;

   instruction_prefetch_if bus ();

   instruction_prefetch #(
      .DEPTH    (4),
      .RESET_PC (32'h100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: each word is derived from its own address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   logic [31:0] resp_q[$];
   logic [31:0] req_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_ins_q[$];
   bit          stall_resp;

   // Zero-wait agent with one-cycle latency; stall_resp holds responses back.
   initial begin
      bus.ibus_readdatavalid = 1'b0;
      bus.ibus_readdata      = '0;
      forever begin
         @(negedge clk);
         if (!rst) resp_q.delete();
         if (!stall_resp && resp_q.size() > 0) begin
            bus.ibus_readdatavalid = 1'b1;
            bus.ibus_readdata      = mem_word(resp_q.pop_front());
         end else begin
            bus.ibus_readdatavalid = 1'b0;
            bus.ibus_readdata      = '0;
         end
         if (rst && bus.ibus_read && !bus.ibus_waitrequest) resp_q.push_back(bus.ibus_address);
      end
   end

   // Log accepted requests and consumed instructions for the coming edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && bus.ibus_read && !bus.ibus_waitrequest) req_q.push_back(bus.ibus_address);
         if (rst && bus.ins_valid && bus.ins_ready && !bus.redirect) begin
            pop_pc_q.push_back(bus.ins_pc);
            pop_ins_q.push_back(bus.ins);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      req_q.delete();
      pop_pc_q.delete();
      pop_ins_q.delete();
   endtask

   // Holds reset for two edges, releases it between edges; returns just after the first edge.
   task automatic do_reset(input logic ready);
      rst                  = 1'b0;
      bus.redirect         = 1'b0;
      bus.redirect_pc      = '0;
      bus.ins_ready        = ready;
      bus.ibus_waitrequest = 1'b0;
      stall_resp           = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      rst = 1'b1;
      clear_logs();
      cyc();
   endtask

   task automatic test_reset();
      rst                  = 1'b0;
      bus.redirect         = 1'b0;
      bus.redirect_pc      = '0;
      bus.ins_ready        = 1'b1;
      bus.ibus_waitrequest = 1'b0;
      stall_resp           = 1'b0;
      cyc();
      cyc();
      checks++;
      if (bus.ibus_read !== 1'b0) $display("FAIL reset_read: got %b want 0", bus.ibus_read);
      else passed++;
      checks++;
      if (bus.ibus_address !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.ibus_address);
      else passed++;
      checks++;
      if (bus.ins_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.ins_valid);
      else passed++;
      checks++;
      if (bus.ins !== 32'h0 || bus.ins_pc !== 32'h0)
         $display("FAIL reset_ins: got %h/%h want 0/0", bus.ins, bus.ins_pc);
      else passed++;
      checks++;
      if (bus.ibus_byteenable !== 4'hf)
         $display("FAIL byteenable: got %h want f", bus.ibus_byteenable);
      else passed++;
      @(negedge clk);
      rst = 1'b1;
      clear_logs();
      cyc();
      checks++;
      if (bus.ibus_read !== 1'b1 || bus.ibus_address !== 32'h100)
         $display("FAIL first_req: got read=%b addr=%h want 1/00000100",
                  bus.ibus_read, bus.ibus_address);
      else passed++;
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      for (int i = 0; i < 16; i++) cyc();
      checks++;
      if (pop_pc_q.size() != 14) $display("FAIL stream_rate: got %0d pops want 14", pop_pc_q.size());
      else passed++;
      for (int i = 0; i < 8; i++) begin
         exp = 32'h100 + 32'(i) * 32'd4;
         checks++;
         if (req_q[i] !== exp) $display("FAIL stream_req[%0d]: got %h want %h", i, req_q[i], exp);
         else passed++;
         checks++;
         if (pop_pc_q[i] !== exp || pop_ins_q[i] !== mem_word(exp))
            $display("FAIL stream_ins[%0d]: got %h/%h want %h/%h", i, pop_pc_q[i], pop_ins_q[i],
                     exp, mem_word(exp));
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      do_reset(1'b0);
      for (int i = 0; i < 20; i++) cyc();
      checks++;
      if (req_q.size() != 4) $display("FAIL bp_reqs: got %0d want 4", req_q.size());
      else passed++;
      checks++;
      if (bus.ibus_read !== 1'b0) $display("FAIL bp_read: got %b want 0", bus.ibus_read);
      else passed++;
      checks++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h100 || bus.ins !== mem_word(32'h100))
         $display("FAIL bp_head: got %b/%h/%h want 1/00000100/%h", bus.ins_valid, bus.ins_pc,
                  bus.ins, mem_word(32'h100));
      else passed++;
      bus.ins_ready = 1'b1;
      for (int i = 0; i < 20; i++) cyc();
      checks++;
      if (pop_pc_q.size() != 20) $display("FAIL bp_resume: got %0d pops want 20", pop_pc_q.size());
      else passed++;
      for (int i = 0; i < pop_pc_q.size(); i++) begin
         exp = 32'h100 + 32'(i) * 32'd4;
         checks++;
         if (pop_pc_q[i] !== exp || pop_ins_q[i] !== mem_word(exp))
            $display("FAIL bp_ins[%0d]: got %h/%h want %h/%h", i, pop_pc_q[i], pop_ins_q[i],
                     exp, mem_word(exp));
         else passed++;
      end
   endtask

   task automatic test_waitrequest();
      logic [31:0] exp;
      int          n;
      do_reset(1'b1);
      n = 0;
      while (bus.ibus_address !== 32'h108 && n < 10) begin
         cyc();
         n++;
      end
      bus.ibus_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.ibus_read !== 1'b1 || bus.ibus_address !== 32'h108)
            $display("FAIL wait_hold[%0d]: got read=%b addr=%h want 1/00000108", i,
                     bus.ibus_read, bus.ibus_address);
         else passed++;
         if (i == 2) bus.ibus_waitrequest = 1'b0;
         cyc();
      end
      for (int i = 0; i < 14; i++) cyc();
      checks++;
      if (req_q.size() < 8) $display("FAIL wait_reqs: got %0d want >= 8", req_q.size());
      else passed++;
      for (int i = 0; i < req_q.size(); i++) begin
         exp = 32'h100 + 32'(i) * 32'd4;
         checks++;
         if (req_q[i] !== exp) $display("FAIL wait_req[%0d]: got %h want %h", i, req_q[i], exp);
         else passed++;
      end
      for (int i = 0; i < pop_pc_q.size(); i++) begin
         exp = 32'h100 + 32'(i) * 32'd4;
         checks++;
         if (pop_pc_q[i] !== exp || pop_ins_q[i] !== mem_word(exp))
            $display("FAIL wait_ins[%0d]: got %h/%h want %h/%h", i, pop_pc_q[i], pop_ins_q[i],
                     exp, mem_word(exp));
         else passed++;
      end
   endtask

   task automatic test_redirect();
      logic [31:0] exp;
      int          n;
      do_reset(1'b1);
      stall_resp = 1'b1;
      n = 0;
      while (req_q.size() < 3 && n < 10) begin
         cyc();
         n++;
      end
      checks++;
      if (req_q.size() != 3) $display("FAIL redir_setup: got %0d reads want 3", req_q.size());
      else passed++;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h2002;
      stall_resp      = 1'b0;
      cyc();
      bus.redirect = 1'b0;
      clear_logs();
      checks++;
      if (bus.ins_valid !== 1'b0 || bus.ibus_read !== 1'b0 || bus.ibus_address !== 32'h0)
         $display("FAIL redir_quiet: got valid=%b read=%b addr=%h want 0/0/0", bus.ins_valid,
                  bus.ibus_read, bus.ibus_address);
      else passed++;
      for (int i = 0; i < 16; i++) cyc();
      checks++;
      if (req_q.size() == 0 || req_q[0] !== 32'h2000)
         $display("FAIL redir_req: got %0d reqs first %h want 00002000", req_q.size(),
                  req_q.size() ? req_q[0] : 32'h0);
      else passed++;
      checks++;
      if (pop_pc_q.size() < 4) $display("FAIL redir_pops: got %0d want >= 4", pop_pc_q.size());
      else passed++;
      for (int i = 0; i < pop_pc_q.size(); i++) begin
         exp = 32'h2000 + 32'(i) * 32'd4;
         checks++;
         if (pop_pc_q[i] !== exp || pop_ins_q[i] !== mem_word(exp))
            $display("FAIL redir_ins[%0d]: got %h/%h want %h/%h", i, pop_pc_q[i], pop_ins_q[i],
                     exp, mem_word(exp));
         else passed++;
      end
   endtask

   task automatic test_redirect_hold();
      logic [31:0] exp;
      int          n;
      do_reset(1'b1);
      n = 0;
      while (bus.ibus_address !== 32'h108 && n < 10) begin
         cyc();
         n++;
      end
      // Read to 0x108 stalls while the 0x104 response arrives in the redirect cycle.
      bus.ibus_waitrequest = 1'b1;
      bus.redirect         = 1'b1;
      bus.redirect_pc      = 32'h3000;
      cyc();
      bus.redirect = 1'b0;
      clear_logs();
      checks++;
      if (bus.ibus_read !== 1'b1 || bus.ibus_address !== 32'h108 || bus.ins_valid !== 1'b0)
         $display("FAIL rh_frozen: got read=%b addr=%h valid=%b want 1/00000108/0",
                  bus.ibus_read, bus.ibus_address, bus.ins_valid);
      else passed++;
      cyc();
      bus.ibus_waitrequest = 1'b0;
      for (int i = 0; i < 15; i++) cyc();
      checks++;
      if (req_q.size() < 2 || req_q[0] !== 32'h108 || req_q[1] !== 32'h3000)
         $display("FAIL rh_reqs: got %0d reqs %h,%h want 00000108,00003000", req_q.size(),
                  req_q.size() > 0 ? req_q[0] : 32'h0, req_q.size() > 1 ? req_q[1] : 32'h0);
      else passed++;
      checks++;
      if (pop_pc_q.size() < 4) $display("FAIL rh_pops: got %0d want >= 4", pop_pc_q.size());
      else passed++;
      for (int i = 0; i < pop_pc_q.size(); i++) begin
         exp = 32'h3000 + 32'(i) * 32'd4;
         checks++;
         if (pop_pc_q[i] !== exp || pop_ins_q[i] !== mem_word(exp))
            $display("FAIL rh_ins[%0d]: got %h/%h want %h/%h", i, pop_pc_q[i], pop_ins_q[i],
                     exp, mem_word(exp));
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] exp;
      int          n;
      do_reset(1'b1);
      n = 0;
      while (bus.ibus_address !== 32'h108 && n < 10) begin
         cyc();
         n++;
      end
      bus.ibus_waitrequest = 1'b1;
      cyc();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.ibus_read !== 1'b0 || bus.ibus_address !== 32'h0)
         $display("FAIL arst_bus: got read=%b addr=%h want 0/0", bus.ibus_read, bus.ibus_address);
      else passed++;
      checks++;
      if (bus.ins_valid !== 1'b0 || bus.ins !== 32'h0 || bus.ins_pc !== 32'h0)
         $display("FAIL arst_ins: got %b/%h/%h want 0/0/0", bus.ins_valid, bus.ins, bus.ins_pc);
      else passed++;
      bus.ibus_waitrequest = 1'b0;
      cyc();
      #1;
      rst = 1'b1;
      clear_logs();
      cyc();
      checks++;
      if (bus.ibus_read !== 1'b1 || bus.ibus_address !== 32'h100)
         $display("FAIL arst_restart: got read=%b addr=%h want 1/00000100", bus.ibus_read,
                  bus.ibus_address);
      else passed++;
      for (int i = 0; i < 12; i++) cyc();
      checks++;
      if (pop_pc_q.size() < 4) $display("FAIL arst_pops: got %0d want >= 4", pop_pc_q.size());
      else passed++;
      for (int i = 0; i < pop_pc_q.size(); i++) begin
         exp = 32'h100 + 32'(i) * 32'd4;
         checks++;
         if (pop_pc_q[i] !== exp || pop_ins_q[i] !== mem_word(exp))
            $display("FAIL arst_ins[%0d]: got %h/%h want %h/%h", i, pop_pc_q[i], pop_ins_q[i],
                     exp, mem_word(exp));
         else passed++;
      end
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_waitrequest();
      test_redirect();
      test_redirect_hold();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
